// File: rtl/pos_vec_decoder.sv
// Rebuilds a bit vector from a framed stream of set-bit positions (lowest-first),
// reporting beat count and an ordering error through a one-deep output register.
module pos_vec_decoder #(
  parameter  int POS_W = 2,
  localparam int VEC_W = 2**POS_W,
  localparam int CNT_W = POS_W + 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POS_W-1:0] in_pos,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vec,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} phase_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [VEC_W-1:0] ONE     = {{(VEC_W-1){1'b0}}, 1'b1};

  phase_t           phase_q, phase_d;
  logic [VEC_W-1:0] acc_q, acc_d;
  logic [POS_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [VEC_W-1:0] out_vec_q, out_vec_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic [VEC_W-1:0] acc_beat;
  logic [CNT_W-1:0] cnt_beat;
  logic             err_beat;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      phase_q     <= IDLE;
      acc_q       <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  always_comb begin
    // out_ready -> in_ready is the only combinational path through the block
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    acc_beat = acc_q | (ONE << in_pos);
    cnt_beat = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    err_beat = err_q | ((phase_q == ACCUM) && (in_pos <= prev_q));

    phase_d     = phase_q;
    acc_d       = acc_q;
    prev_d      = prev_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (in_last) begin
        out_valid_d = 1'b1;
        out_vec_d   = acc_beat;
        out_count_d = cnt_beat;
        out_err_d   = err_beat;
        phase_d     = IDLE;
        acc_d       = '0;
        prev_d      = '0;
        cnt_d       = '0;
        err_d       = 1'b0;
      end else begin
        phase_d = ACCUM;
        acc_d   = acc_beat;
        prev_d  = in_pos;
        cnt_d   = cnt_beat;
        err_d   = err_beat;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_pos_vec_decoder.sv
// Directed bench for pos_vec_decoder: framing, ordering errors, backpressure,
// async reset and count saturation, with hand-computed expectations.
module tb_pos_vec_decoder;

  logic       clk = 1'b0;
  logic       areset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_pos;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_vec;
  logic [2:0] out_count;
  logic       out_err;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  pos_vec_decoder #(.POS_W(2)) dut (
    .clk(clk), .areset(areset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pos(in_pos), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_count(out_count), .out_err(out_err)
  );

  // Present one beat for exactly one edge; returns 1ns after that edge.
  task automatic send(input logic [1:0] p, input logic l);
    in_valid = 1'b1; in_pos = p; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    areset = 1'b1; in_valid = 1'b0; in_pos = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else pass_cnt++;
    tot_cnt++; if (out_vec !== 4'b0000) $display("FAIL reset_vec got=%b exp=0000", out_vec); else pass_cnt++;
    tot_cnt++; if (out_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", out_count); else pass_cnt++;
    tot_cnt++; if (out_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", out_err); else pass_cnt++;
    areset = 1'b0;
    idle_cycle();
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    send(2'd0, 1'b0);
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_midframe_valid got=%b exp=0", out_valid); else pass_cnt++;
    send(2'd2, 1'b0);
    send(2'd3, 1'b1);
    tot_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid); else pass_cnt++;
    tot_cnt++; if (out_vec !== 4'b1101) $display("FAIL basic_vec got=%b exp=1101", out_vec); else pass_cnt++;
    tot_cnt++; if (out_count !== 3'd3) $display("FAIL basic_count got=%0d exp=3", out_count); else pass_cnt++;
    tot_cnt++; if (out_err !== 1'b0) $display("FAIL basic_err got=%b exp=0", out_err); else pass_cnt++;
    idle_cycle();
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_pulse got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_single_b2b();
    logic [3:0] ev;
    send(2'd3, 1'b1);
    tot_cnt++; if (out_vec !== 4'b1000) $display("FAIL single_vec got=%b exp=1000", out_vec); else pass_cnt++;
    tot_cnt++; if (out_count !== 3'd1) $display("FAIL single_count got=%0d exp=1", out_count); else pass_cnt++;
    tot_cnt++; if (out_err !== 1'b0) $display("FAIL single_err got=%b exp=0", out_err); else pass_cnt++;
    for (int p = 0; p < 4; p++) begin
      ev = 4'b0001 << p;
      send(2'(p), 1'b1);
      tot_cnt++;
      if (out_valid !== 1'b1 || out_vec !== ev || out_count !== 3'd1 || out_err !== 1'b0)
        $display("FAIL b2b_%0d got v=%b vec=%b cnt=%0d err=%b exp v=1 vec=%b cnt=1 err=0",
                 p, out_valid, out_vec, out_count, out_err, ev);
      else pass_cnt++;
    end
    idle_cycle();
  endtask

  task automatic test_order_err();
    send(2'd2, 1'b0);
    send(2'd1, 1'b1);
    tot_cnt++; if (out_vec !== 4'b0110) $display("FAIL ooo_vec got=%b exp=0110", out_vec); else pass_cnt++;
    tot_cnt++; if (out_count !== 3'd2) $display("FAIL ooo_count got=%0d exp=2", out_count); else pass_cnt++;
    tot_cnt++; if (out_err !== 1'b1) $display("FAIL ooo_err got=%b exp=1", out_err); else pass_cnt++;
    send(2'd1, 1'b0);
    send(2'd1, 1'b1);
    tot_cnt++; if (out_vec !== 4'b0010) $display("FAIL dup_vec got=%b exp=0010", out_vec); else pass_cnt++;
    tot_cnt++; if (out_count !== 3'd2) $display("FAIL dup_count got=%0d exp=2", out_count); else pass_cnt++;
    tot_cnt++; if (out_err !== 1'b1) $display("FAIL dup_err got=%b exp=1", out_err); else pass_cnt++;
    // a clean frame right after an errored one must not inherit the flag
    send(2'd0, 1'b0);
    send(2'd1, 1'b1);
    tot_cnt++; if (out_err !== 1'b0 || out_vec !== 4'b0011) $display("FAIL clean_after_err got err=%b vec=%b exp err=0 vec=0011", out_err, out_vec); else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(2'd1, 1'b1);
    tot_cnt++; if (out_valid !== 1'b1 || out_vec !== 4'b0010) $display("FAIL bp_load got v=%b vec=%b exp v=1 vec=0010", out_valid, out_vec); else pass_cnt++;
    in_valid = 1'b1; in_pos = 2'd3; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      tot_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== 4'b0010 || out_count !== 3'd1)
        $display("FAIL bp_hold_%0d got rdy=%b v=%b vec=%b cnt=%0d exp rdy=0 v=1 vec=0010 cnt=1",
                 c, in_ready, out_valid, out_vec, out_count);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_comb got=%b exp=1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tot_cnt++; if (out_valid !== 1'b1 || out_vec !== 4'b1000 || out_count !== 3'd1 || out_err !== 1'b0)
      $display("FAIL bp_swap got v=%b vec=%b cnt=%0d err=%b exp v=1 vec=1000 cnt=1 err=0", out_valid, out_vec, out_count, out_err);
    else pass_cnt++;
    idle_cycle();
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(2'd2, 1'b1);
    #2 areset = 1'b1;
    #1;
    tot_cnt++; if (out_valid !== 1'b0 || out_vec !== 4'b0000 || out_count !== 3'd0 || out_err !== 1'b0)
      $display("FAIL areset_async got v=%b vec=%b cnt=%0d err=%b exp all 0", out_valid, out_vec, out_count, out_err);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    send(2'd1, 1'b0);
    #2 areset = 1'b1;
    #1;
    tot_cnt++; if (out_valid !== 1'b0 || out_vec !== 4'b0000 || in_ready !== 1'b1)
      $display("FAIL areset_midframe got v=%b vec=%b rdy=%b exp v=0 vec=0000 rdy=1", out_valid, out_vec, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    areset = 1'b0;
    send(2'd2, 1'b1);
    tot_cnt++; if (out_vec !== 4'b0100) $display("FAIL areset_after_vec got=%b exp=0100", out_vec); else pass_cnt++;
    tot_cnt++; if (out_count !== 3'd1) $display("FAIL areset_after_count got=%0d exp=1", out_count); else pass_cnt++;
    tot_cnt++; if (out_err !== 1'b0) $display("FAIL areset_after_err got=%b exp=0", out_err); else pass_cnt++;
    idle_cycle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) send(2'd0, 1'b0);
    send(2'd0, 1'b1);
    tot_cnt++; if (out_count !== 3'd7) $display("FAIL sat_count got=%0d exp=7", out_count); else pass_cnt++;
    tot_cnt++; if (out_vec !== 4'b0001) $display("FAIL sat_vec got=%b exp=0001", out_vec); else pass_cnt++;
    tot_cnt++; if (out_err !== 1'b1) $display("FAIL sat_err got=%b exp=1", out_err); else pass_cnt++;
    // seven beats exactly reaches the maximum without wrapping on the way
    for (int i = 0; i < 6; i++) send(2'(i % 4), 1'b0);
    send(2'd3, 1'b1);
    tot_cnt++; if (out_count !== 3'd7) $display("FAIL sat7_count got=%0d exp=7", out_count); else pass_cnt++;
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_b2b();
    test_order_err();
    test_backpressure();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
